// File: rtl/f_branch_predictor_if.sv
// Fetch/decode side signals of the f_branch_predictor block.
// master = pipeline side driving fetch PC and decode resolution, slave = predictor.
interface f_branch_predictor_if;
   logic [12:0] f_pc;
   logic        f_stall;
   logic [12:0] pred_nextpc;
   logic [12:0] pc_predicted;
   logic        cannot_predict;
   logic [12:0] d_pc;
   logic [12:0] d_nextpc;
   logic [1:0]  d_jump_code;
   logic        d_fail_predict;
   logic        ready;

   modport master (
      output f_pc, f_stall, d_pc, d_nextpc, d_jump_code, d_fail_predict,
      input  pred_nextpc, pc_predicted, cannot_predict, ready
   );

   modport slave (
      input  f_pc, f_stall, d_pc, d_nextpc, d_jump_code, d_fail_predict,
      output pred_nextpc, pc_predicted, cannot_predict, ready
   );
endinterface

// File: rtl/f_branch_predictor.sv
// Direct-mapped BTB fetch predictor with 2-bit counters, trained from decode.
// Optional macro BTB_JALR_PREDICT_EN: when defined, jalr allocates like jal.
module f_branch_predictor #(
   parameter int IDX_BITS = 4
) (
   input logic                 clk,
   input logic                 rst,
   f_branch_predictor_if.slave bp
);
   localparam int PC_W    = 13;
   localparam int ENTRIES = 1 << IDX_BITS;
   localparam int TAG_W   = PC_W - IDX_BITS;

   typedef enum logic {INIT, RUN} state_t;

   state_t              state_reg, state_next;
   logic [IDX_BITS-1:0] init_cnt_reg, init_cnt_next;
   logic                init_clear;

   logic [ENTRIES-1:0]  valid_reg, valid_next;
   logic [TAG_W-1:0]    tag_mem    [ENTRIES];
   logic [PC_W-1:0]     target_mem [ENTRIES];
   logic [1:0]          ctr_mem    [ENTRIES];
   logic                uncond_mem [ENTRIES];

   logic [PC_W-1:0]     pc_predicted_reg;
   logic                cannot_predict_reg;

   // ---------------- init / run FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= INIT;
         init_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         init_cnt_reg <= init_cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      init_cnt_next = init_cnt_reg;
      init_clear    = 1'b0;
      case (state_reg)
         INIT: begin
            init_clear    = 1'b1;
            init_cnt_next = init_cnt_reg + 1'b1;
            if (init_cnt_reg == IDX_BITS'(ENTRIES - 1))
               state_next = RUN;
         end
         default: ;
      endcase
   end

   assign bp.ready = (state_reg == RUN);

   // ---------------- combinational lookup ----------------
   logic [IDX_BITS-1:0] f_idx;
   logic [TAG_W-1:0]    f_tag;
   logic [PC_W-1:0]     f_pc_inc;
   logic                f_hit;

   assign f_idx    = bp.f_pc[IDX_BITS-1:0];
   assign f_tag    = bp.f_pc[PC_W-1:IDX_BITS];
   assign f_pc_inc = bp.f_pc + 13'd1;
   assign f_hit    = (state_reg == RUN) && valid_reg[f_idx] && (tag_mem[f_idx] == f_tag);

   assign bp.pred_nextpc = (f_hit && (uncond_mem[f_idx] || ctr_mem[f_idx][1]))
                           ? target_mem[f_idx] : f_pc_inc;

   // ---------------- fetch/decode pipeline register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_predicted_reg   <= '0;
         cannot_predict_reg <= 1'b1;
      end else if (bp.d_fail_predict) begin
         pc_predicted_reg   <= bp.d_nextpc;
         cannot_predict_reg <= 1'b1;
      end else if (!bp.f_stall) begin
         pc_predicted_reg   <= bp.pred_nextpc;
         cannot_predict_reg <= 1'b0;
      end
   end

   assign bp.pc_predicted   = pc_predicted_reg;
   assign bp.cannot_predict = cannot_predict_reg;

   // ---------------- training from decode ----------------
   logic [IDX_BITS-1:0] d_idx;
   logic [TAG_W-1:0]    d_tag;
   logic [PC_W-1:0]     d_pc_inc;
   logic                d_hit, d_taken, upd_en;
   logic                wr_en, wr_uncond;
   logic [PC_W-1:0]     wr_target;
   logic [1:0]          wr_ctr;

   assign d_idx    = bp.d_pc[IDX_BITS-1:0];
   assign d_tag    = bp.d_pc[PC_W-1:IDX_BITS];
   assign d_pc_inc = bp.d_pc + 13'd1;
   assign d_hit    = valid_reg[d_idx] && (tag_mem[d_idx] == d_tag);
   assign d_taken  = (bp.d_nextpc != d_pc_inc);
   // A bubble slot carries no real instruction, so it never trains.
   assign upd_en   = (state_reg == RUN) && !cannot_predict_reg && (bp.d_jump_code != 2'b00);

   always_comb begin
      wr_en     = 1'b0;
      wr_target = target_mem[d_idx];
      wr_ctr    = ctr_mem[d_idx];
      wr_uncond = uncond_mem[d_idx];
      if (upd_en) begin
         case (bp.d_jump_code)
            2'b01: begin
               if (d_hit) begin
                  wr_en = 1'b1;
                  if (d_taken) begin
                     wr_target = bp.d_nextpc;
                     if (ctr_mem[d_idx] != 2'b11) wr_ctr = ctr_mem[d_idx] + 2'b01;
                  end else if (ctr_mem[d_idx] != 2'b00) begin
                     wr_ctr = ctr_mem[d_idx] - 2'b01;
                  end
               end else if (d_taken) begin
                  wr_en     = 1'b1;
                  wr_target = bp.d_nextpc;
                  wr_ctr    = 2'b10;
                  wr_uncond = 1'b0;
               end
            end
            2'b10: begin
               wr_en     = 1'b1;
               wr_target = bp.d_nextpc;
               wr_ctr    = 2'b11;
               wr_uncond = 1'b1;
            end
            2'b11: begin
`ifdef BTB_JALR_PREDICT_EN
               wr_en     = 1'b1;
               wr_target = bp.d_nextpc;
               wr_ctr    = 2'b11;
               wr_uncond = 1'b1;
`endif
            end
            default: ;
         endcase
      end
   end

   // Per-entry valid: init sweep clears, any table write sets.
   for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_valid
      assign valid_next[gi] = (init_clear && init_cnt_reg == IDX_BITS'(gi)) ? 1'b0 :
                              (wr_en && d_idx == IDX_BITS'(gi))             ? 1'b1 :
                              valid_reg[gi];
   end

   always_ff @(posedge clk) begin
      valid_reg <= valid_next;
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[d_idx]    <= d_tag;
         target_mem[d_idx] <= wr_target;
         ctr_mem[d_idx]    <= wr_ctr;
         uncond_mem[d_idx] <= wr_uncond;
      end
   end
endmodule

// File: doc/f_branch_predictor.md
Name: f_branch_predictor

Overview:
- Fetch-side branch predictor; producer end of the decode-stage prediction check.
- Direct-mapped BTB with 2-bit saturating counters, looked up combinationally with fetch PC to give next fetch PC.
- Prediction is registered into the fetch/decode pipeline register as pc_predicted/cannot_predict.
- Trained from decode's resolved next PC, jump code and mispredict flag.

Parameters:
- IDX_BITS, 4, BTB index width; 2^IDX_BITS entries; index = pc[IDX_BITS-1:0], tag = pc[12:IDX_BITS]
- PC_W, 13, word-address PC width; fixed at 13, not to be overridden

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- f_pc  in  13  current fetch PC (word address)
- f_stall  in  1  fetch/decode register hold
- pred_nextpc  out  13  combinational predicted next fetch PC
- pc_predicted  out  13  registered prediction for instruction entering decode
- cannot_predict  out  1  registered; 1 = decode must not check this slot (bubble)
- d_pc  in  13  PC of instruction in decode
- d_nextpc  in  13  resolved next PC from decode
- d_jump_code  in  2  00 none, 01 branch, 10 jal, 11 jalr
- d_fail_predict  in  1  decode mispredict (already gated by cannot_predict in decode)
- ready  out  1  1 when table init done

Behaviour:
- Entry fields: valid, tag[12-IDX_BITS:0], target[12:0], ctr[1:0], uncond.
- FSM INIT/RUN. rst -> INIT, init counter = 0. INIT: clear valid[cnt], cnt++; after entry 2^IDX_BITS-1 cleared -> RUN. Init takes exactly 2^IDX_BITS cycles; ready = (state==RUN). rst mid-RUN restarts INIT.
- Lookup, combinational: hit = RUN & valid & tag match. pred_nextpc = target if hit & (uncond | ctr[1]); else f_pc+1 (13-bit wrap, 0x1FFF+1 = 0x0000). In INIT always f_pc+1.
- Pipeline register, latency 1:
  - rst: pc_predicted = 0, cannot_predict = 1.
  - d_fail_predict: cannot_predict <= 1, pc_predicted <= d_nextpc. Squashes the wrong-path slot; overrides f_stall.
  - else f_stall: hold both.
  - else: pc_predicted <= pred_nextpc, cannot_predict <= 0.
- Update (RUN only, when !cannot_predict & d_jump_code != 00), indexed by d_pc; happens regardless of f_stall:
  - Branch (01): taken = (d_nextpc != d_pc+1).
    - Hit: ctr saturating inc if taken, dec if not (3 and 0 saturate); target <= d_nextpc if taken.
    - Miss & taken: allocate, ctr = 2'b10, uncond = 0.
    - Miss & not taken: no write.
  - jal (10): allocate/overwrite, target = d_nextpc, uncond = 1, ctr = 2'b11.
  - jalr (11): see optional feature.
  - Allocation overwrites any entry at that index (no replacement policy).
- Same-cycle lookup and update to the same index: lookup uses pre-update contents; no bypass.
- Update writes are ignored in INIT.

Optional Feature:
- Macro: BTB_JALR_PREDICT_EN.
- Defined: jalr treated like jal; allocate with target = d_nextpc, uncond = 1.
- Undefined: jalr never writes the table; a hit on a jalr PC cannot exist, so fetch predicts pc+1.

Test Plan:
- Reset then idle -> cannot_predict=1, pc_predicted=0, ready=0 for 16 cycles (IDX_BITS=4); ready=1 on cycle 17; all lookups give f_pc+1.
- Branch at d_pc=0x010, taken to 0x004 with d_fail_predict=1 -> next cycle cannot_predict=1, pc_predicted=0x004; then f_pc=0x010 gives pred_nextpc=0x004.
- Same branch resolved not-taken twice (ctr 2->1->0) -> after first, f_pc=0x010 gives 0x011; ctr stays 0 on a third not-taken.
- jal at 0x020 -> 0x100, then jal at 0x030 (same index, different tag) -> 0x200 -> f_pc=0x020 gives 0x021; f_pc=0x030 gives 0x200.
- f_stall=1 for 3 cycles with changing f_pc -> pc_predicted/cannot_predict held; d_fail_predict during stall -> cannot_predict=1, pc_predicted=d_nextpc.
- jalr at 0x040 -> 0x080: with BTB_JALR_PREDICT_EN, f_pc=0x040 gives 0x080; without it, gives 0x041.
